spike_interval_decoder: RTL and testbench
=========================================

// Module: spike_interval_decoder
// PURPOSE
//   Receiving end of the neuron/synapse spike link: decodes a spike train back into numbers.
//   Edge-detects spike_in and measures the inter-spike interval (ISI) in clock cycles.
//   Delivers each ISI over a valid/ready handshake and reports a windowed spike count (rate).
//   Sits after a neuron or synapse output in the top level; feeds uo_out/uio_out or a host reader.
// PARAMETERS
//   ISI_W        16    width of ISI counter/output; MAX_ISI = 2**ISI_W-1
//   RATE_W       8     width of windowed spike count
//   WINDOW       1000  rate window length in enabled cycles (>=2)
//   SYNC_STAGES  2     input synchronizer depth; 0 = spike_in already in clk domain
// PORTS
//   clk          in   1       clock; all logic on rising edge
//   rst_n        in   1       synchronous active-low reset
//   ena          in   1       enable; low freezes counters, state and edge detector
//   spike_in     in   1       spike train (level; a rising edge = one spike)
//   isi_out      out  ISI_W   measured interval, stable while isi_valid=1
//   isi_valid    out  1       holding register full
//   isi_ready    in   1       consumer accepts when isi_valid&isi_ready
//   timeout      out  1       1-cycle pulse: no spike within MAX_ISI cycles
//   overrun      out  1       sticky: an ISI was dropped because the slot was full
//   overrun_clr  in   1       clears overrun (set wins if same cycle)
//   rate_out     out  RATE_W  spikes counted in last completed window (saturating)
//   rate_valid   out  1       1-cycle pulse when rate_out updates
// BEHAVIOUR
//   Reset (rst_n=0 at a clock edge): state=IDLE, counters 0, all outputs 0, sync/edge regs 0.
//   Edge: s = synchronized spike_in; edge = s & ~s_q (s_q updates only when ena=1).
//   Latency: spike_in rise to edge = SYNC_STAGES cycles; edge cycle to isi_valid = 1 cycle.
//   FSM (advances only when ena=1):
//     IDLE    : edge -> MEASURE, cnt<=1; no ISI produced (no reference spike yet).
//     MEASURE : cnt<=cnt+1 each cycle. On edge: ISI=cnt, cnt<=1, stay.
//               If cnt==MAX_ISI and no edge: -> TIMEOUT, timeout pulses, no ISI.
//     TIMEOUT : edge -> MEASURE, cnt<=1 (treated as first spike); no ISI.
//   Edges at cycles t1,t2 give isi_out = t2-t1 (min 2 as edges need a low cycle).
//   Holding register (1 entry):
//     loaded with ISI if empty, or full and accepted same cycle (no bubble).
//     Full and not accepted: new ISI dropped; overrun<=1; old value unchanged.
//     isi_valid/isi_out change only on accept or load; the handshake works even when ena=0.
//   Rate: wcnt counts 0..WINDOW-1 on enabled cycles; edges increment scnt (saturate 2**RATE_W-1).
//     On wcnt==WINDOW-1: rate_out<=scnt (+1 if edge this cycle, saturated), rate_valid=1, scnt<=0.
//     An edge on the last window cycle belongs to the closing window.
//   Reset mid-operation: discards partial ISI, pending output, window count; back to IDLE.
//   ena=0: no state/counter change and no pulses; spike edges during ena=0 are not seen.
// STRUCTURE
//   spike_pkg: isi_state_e {IDLE,MEASURE,TIMEOUT}, default ISI_W/RATE_W constants.
//   Sub-module spike_edge_sync: SYNC_STAGES flop chain + rising-edge detect, ena-gated.
//   Top: FSM + ISI counter, 1-entry output register, window/rate counter.
// TESTING
//   Reset check: after rst_n low 2 cycles, all outputs 0 and state IDLE.
//   Periodic spikes every 10 cycles, ready=1 -> first spike no output; then isi_out=10 each spike.
//   Spikes 10 apart, ready=0 -> first ISI held as 10; second dropped, overrun=1; clr -> 0.
//   ISI_W=4, one spike, then none -> timeout pulse 15 cycles later; next spike gives no ISI.
//   WINDOW=100, spike every 10 cycles -> rate_valid every 100 cycles with rate_out=10.
//   RATE_W=2, 5 spikes per window -> rate_out=3 (saturated); rst_n mid-window -> clean restart.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared types and default widths for the spike-interval decoder.
package spike_pkg;

  localparam int unsigned ISI_W_DEF       = 16;
  localparam int unsigned RATE_W_DEF      = 8;
  localparam int unsigned WINDOW_DEF      = 1000;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } isi_state_e;

endpackage

// File: rtl/spike_edge_sync.sv
// Synchronizes spike_in into clk and flags its rising edges; the whole chain freezes while ena=0.
module spike_edge_sync
  import spike_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic spike_in,
  output logic edge_c
);

  logic s;
  logic s_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = spike_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync <= '0;
        end else if (ena) begin
          sync[0] <= spike_in;
          for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync[i] <= sync[i-1];
          end
        end
      end

      assign s = sync[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q <= 1'b0;
    end else if (ena) begin
      s_q <= s;
    end
  end

  assign edge_c = ena & s & ~s_q;

endmodule

// File: rtl/spike_interval_decoder.sv
// Decodes a spike train into inter-spike intervals (valid/ready) and a windowed spike rate.
module spike_interval_decoder
  import spike_pkg::*;
#(
  parameter int unsigned ISI_W       = ISI_W_DEF,
  parameter int unsigned RATE_W      = RATE_W_DEF,
  parameter int unsigned WINDOW      = WINDOW_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              spike_in,
  output logic [ISI_W-1:0]  isi_out,
  output logic              isi_valid,
  input  logic              isi_ready,
  output logic              timeout,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [RATE_W-1:0] rate_out,
  output logic              rate_valid
);

  localparam int unsigned       WCNT_W   = $clog2(WINDOW);
  localparam logic [ISI_W-1:0]  MAX_ISI  = '1;
  localparam logic [RATE_W-1:0] RATE_MAX = '1;
  localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WINDOW - 1);

  logic spike_edge;

  isi_state_e        state, state_d;
  logic [ISI_W-1:0]  cnt, cnt_d;
  logic              isi_new;
  logic              timeout_d;

  logic              accept;
  logic [ISI_W-1:0]  isi_out_d;
  logic              isi_valid_d;
  logic              overrun_d;

  logic [WCNT_W-1:0] wcnt, wcnt_d;
  logic [RATE_W-1:0] scnt, scnt_d, scnt_inc;
  logic [RATE_W-1:0] rate_out_d;
  logic              rate_valid_d;

  spike_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .spike_in(spike_in),
    .edge_c  (spike_edge)
  );

  // Interval FSM: the first spike (or the first after a timeout) only sets the reference.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    isi_new   = 1'b0;
    timeout_d = 1'b0;
    if (ena) begin
      unique case (state)
        IDLE, TIMEOUT: begin
          if (spike_edge) begin
            state_d = MEASURE;
            cnt_d   = ISI_W'(1);
          end
        end
        MEASURE: begin
          if (spike_edge) begin
            isi_new = 1'b1;
            cnt_d   = ISI_W'(1);
          end else if (cnt == MAX_ISI) begin
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt + ISI_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // One-entry holding slot; a same-cycle accept frees it for the incoming interval.
  always_comb begin
    accept      = isi_valid & isi_ready;
    isi_out_d   = isi_out;
    isi_valid_d = isi_valid;
    overrun_d   = overrun;
    if (accept) begin
      isi_valid_d = 1'b0;
    end
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (isi_new) begin
      if (!isi_valid || accept) begin
        isi_valid_d = 1'b1;
        isi_out_d   = cnt;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Rate window; an edge on the closing cycle is counted in the closing window.
  always_comb begin
    scnt_inc     = (spike_edge && (scnt != RATE_MAX)) ? scnt + RATE_W'(1) : scnt;
    wcnt_d       = wcnt;
    scnt_d       = scnt;
    rate_out_d   = rate_out;
    rate_valid_d = 1'b0;
    if (ena) begin
      if (wcnt == WIN_LAST) begin
        wcnt_d       = '0;
        scnt_d       = '0;
        rate_out_d   = scnt_inc;
        rate_valid_d = 1'b1;
      end else begin
        wcnt_d = wcnt + WCNT_W'(1);
        scnt_d = scnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      timeout    <= 1'b0;
      isi_out    <= '0;
      isi_valid  <= 1'b0;
      overrun    <= 1'b0;
      wcnt       <= '0;
      scnt       <= '0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      timeout    <= timeout_d;
      isi_out    <= isi_out_d;
      isi_valid  <= isi_valid_d;
      overrun    <= overrun_d;
      wcnt       <= wcnt_d;
      scnt       <= scnt_d;
      rate_out   <= rate_out_d;
      rate_valid <= rate_valid_d;
    end
  end

endmodule

// File: tb/tb_spike_interval_decoder.sv
// Scoreboard bench: two decoder instances (wide/long-window and narrow/short-window) share clock and reset.
module tb_spike_interval_decoder;
  import spike_pkg::*;

  localparam int unsigned AW = 16, AR = 8, AWIN = 100;
  localparam int unsigned BW = 4,  BR = 2, BWIN = 20;

  logic clk = 1'b0;
  logic rst_n, ena;

  logic          a_spike, a_ready, a_clr;
  logic [AW-1:0] a_isi_out;
  logic          a_isi_valid, a_timeout, a_overrun, a_rate_valid;
  logic [AR-1:0] a_rate_out;

  logic          b_spike, b_ready, b_clr;
  logic [BW-1:0] b_isi_out;
  logic          b_isi_valid, b_timeout, b_overrun, b_rate_valid;
  logic [BR-1:0] b_rate_out;

  int n_total = 0;
  int n_pass  = 0;
  int qa[$], qb[$], qra[$], qrb[$];
  bit a_rate_arm = 1'b0;
  bit b_rate_arm = 1'b0;

  always #5 clk = ~clk;

  spike_interval_decoder #(.ISI_W(AW), .RATE_W(AR), .WINDOW(AWIN), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(a_spike),
    .isi_out(a_isi_out), .isi_valid(a_isi_valid), .isi_ready(a_ready),
    .timeout(a_timeout), .overrun(a_overrun), .overrun_clr(a_clr),
    .rate_out(a_rate_out), .rate_valid(a_rate_valid)
  );

  spike_interval_decoder #(.ISI_W(BW), .RATE_W(BR), .WINDOW(BWIN), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(b_spike),
    .isi_out(b_isi_out), .isi_valid(b_isi_valid), .isi_ready(b_ready),
    .timeout(b_timeout), .overrun(b_overrun), .overrun_clr(b_clr),
    .rate_out(b_rate_out), .rate_valid(b_rate_valid)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_unexpected(input string name, input int act);
    n_total++;
    $display("FAIL %s: got %0d, expected no output", name, act);
  endtask

  // Monitors: pop the expected value whenever the DUT hands something over.
  always @(negedge clk) begin
    if (a_isi_valid && a_ready) begin
      if (qa.size() == 0) fail_unexpected("a_isi", int'(a_isi_out));
      else check("a_isi", int'(a_isi_out), qa.pop_front());
    end
    if (b_isi_valid && b_ready) begin
      if (qb.size() == 0) fail_unexpected("b_isi", int'(b_isi_out));
      else check("b_isi", int'(b_isi_out), qb.pop_front());
    end
    if (a_rate_valid && a_rate_arm) begin
      if (qra.size() == 0) fail_unexpected("a_rate", int'(a_rate_out));
      else check("a_rate", int'(a_rate_out), qra.pop_front());
    end
    if (b_rate_valid && b_rate_arm) begin
      if (qrb.size() == 0) fail_unexpected("b_rate", int'(b_rate_out));
      else check("b_rate", int'(b_rate_out), qrb.pop_front());
    end
  end

  task automatic reset_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("a_rst_isi_out",    int'(a_isi_out), 0);
    check("a_rst_isi_valid",  int'(a_isi_valid), 0);
    check("a_rst_timeout",    int'(a_timeout), 0);
    check("a_rst_overrun",    int'(a_overrun), 0);
    check("a_rst_rate_out",   int'(a_rate_out), 0);
    check("a_rst_rate_valid", int'(a_rate_valid), 0);
    check("a_rst_state",      int'(u_a.state), int'(IDLE));
    check("b_rst_isi_valid",  int'(b_isi_valid), 0);
    check("b_rst_overrun",    int'(b_overrun), 0);
    check("b_rst_rate_out",   int'(b_rate_out), 0);
    check("b_rst_state",      int'(u_b.state), int'(IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One-cycle-high spike, next rise 'gap' cycles after this one.
  task automatic pulse_gap(input bit sel_b, input int gap);
    if (sel_b) b_spike = 1'b1; else a_spike = 1'b1;
    @(posedge clk); #1;
    if (sel_b) b_spike = 1'b0; else a_spike = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((qa.size() + qb.size() + qra.size() + qrb.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, qa.size() + qb.size() + qra.size() + qrb.size(), 0);
    qa.delete(); qb.delete(); qra.delete(); qrb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; ena = 1'b1;
    a_spike = 1'b0; a_ready = 1'b0; a_clr = 1'b0;
    b_spike = 1'b0; b_ready = 1'b0; b_clr = 1'b0;

    // Periodic spikes every 10 cycles: 24 intervals of 10, two windows of 10 spikes
    reset_all();
    a_ready = 1'b1; b_ready = 1'b1;
    repeat (24) qa.push_back(10);
    qra.push_back(10); qra.push_back(10);
    a_rate_arm = 1'b1;
    repeat (25) pulse_gap(1'b0, 10);
    wait_drain("a_periodic_drain", 200);
    a_rate_arm = 1'b0;

    // Stalled consumer: first interval held, second dropped and flagged
    reset_all();
    a_ready = 1'b0;
    pulse_gap(1'b0, 10); pulse_gap(1'b0, 14); pulse_gap(1'b0, 6);
    @(negedge clk);
    check("a_held_valid", int'(a_isi_valid), 1);
    check("a_held_value", int'(a_isi_out), 10);
    check("a_overrun_set", int'(a_overrun), 1);
    @(posedge clk); #1; a_clr = 1'b1;
    @(posedge clk); #1; a_clr = 1'b0;
    @(negedge clk);
    check("a_overrun_clr", int'(a_overrun), 0);
    check("a_still_held", int'(a_isi_valid), 1);
    qa.push_back(10);
    a_ready = 1'b1;
    wait_drain("a_held_drain", 20);
    @(negedge clk);
    check("a_slot_empty", int'(a_isi_valid), 0);

    // ena low for 5 cycles inside a 15-cycle gap: interval shrinks to 10
    reset_all();
    qa.push_back(10);
    a_spike = 1'b1;
    @(posedge clk); #1; a_spike = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    ena = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    ena = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    pulse_gap(1'b0, 5);
    wait_drain("a_ena_drain", 20);

    // Narrow counter: a single spike times out 15 cycles after its edge
    reset_all();
    b_ready = 1'b1;
    b_spike = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2) b_spike = 1'b0;
      if (b_timeout) seen = 1'b1;
    end
    check("b_timeout_latency", n, 19);
    check("b_state_timeout", int'(u_b.state), int'(TIMEOUT));
    @(negedge clk);
    check("b_timeout_width", int'(b_timeout), 0);
    qb.push_back(6);
    pulse_gap(1'b1, 6); pulse_gap(1'b1, 6);
    wait_drain("b_after_timeout_drain", 20);

    // 5 spikes per 20-cycle window saturate a 2-bit rate at 3
    reset_all();
    repeat (9) qb.push_back(4);
    qrb.push_back(3); qrb.push_back(3);
    b_rate_arm = 1'b1;
    repeat (10) pulse_gap(1'b1, 4);
    wait_drain("b_sat_drain", 20);
    b_rate_arm = 1'b0;

    // Reset with a pending interval and overrun, then a clean restart
    b_ready = 1'b0;
    pulse_gap(1'b1, 7); pulse_gap(1'b1, 7);
    @(negedge clk);
    check("b_pending_before_rst", int'(b_isi_valid), 1);
    check("b_overrun_before_rst", int'(b_overrun), 1);
    reset_all();
    b_ready = 1'b1;
    qb.push_back(7);
    qrb.push_back(2);
    b_rate_arm = 1'b1;
    pulse_gap(1'b1, 7); pulse_gap(1'b1, 7);
    wait_drain("b_restart_drain", 40);
    b_rate_arm = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
